inst_field_encoder: RTL

- Inverse of the pipeline's immediate generation: packs opcode, register fields and a 32-bit immediate into one 32-bit instruction word.
- Range-checks the immediate against the extension rule the decode side will apply, so re-decoding the word returns the original immediate.
- Used by the boot/self-test loader to stream encoded words into instruction memory.
- Two-stage valid/ready pipeline with an auto-incrementing write address.

---
 rtl/inst_field_encoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/inst_field_encoder.sv
// inst_field_encoder: packs opcode, register fields and a 32-bit immediate
// into a 32-bit instruction word for the boot/self-test loader. Immediates
// are range-checked against the extension the decoder applies, so a word
// that re-decodes to a different immediate is rejected (forced to zero,
// out_err set) but still delivered at its own address.
// Two-stage valid/ready pipeline; stage 1 holds fields plus the check
// result, stage 2 is the output register with an auto-incrementing address.
// Optional: define INST_ENC_ERRCNT_EN to build the saturating rejected-word
// counter on err_cnt; otherwise err_cnt is tied to zero.
module inst_field_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [11:0]       opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   input  logic              addr_clr,
   output logic [7:0]        err_cnt
);

   // Major opcode field (opcode[11:6]) and R-format function codes.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;

   function automatic logic is_shift(input logic [5:0] funct);
      return (funct == FN_SLL) || (funct == FN_SRL);
   endfunction

   // Shift amount must fit the 5-bit shamt field.
   function automatic logic fits_shamt(input logic [31:0] v);
      return ~|v[31:5];
   endfunction

   // Decoder zero-extends: upper half must be clear.
   function automatic logic fits_zext16(input logic [31:0] v);
      return ~|v[31:16];
   endfunction

   // Decoder sign-extends bit 15: bits 31..15 must all match.
   function automatic logic fits_sext16(input logic [31:0] v);
      return (&v[31:15]) | (~|v[31:15]);
   endfunction

   logic [31:0]       enc_inst;
   logic              enc_err;
   logic              vld_p1;
   logic [31:0]       inst_p1;
   logic              err_p1;
   logic              adv_p2;
   logic              in_fire;
   logic              out_fire;
   logic [ADDR_W-1:0] addr_q;

   assign adv_p2   = ~out_valid | out_ready;
   assign in_ready = ~vld_p1 | adv_p2;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign out_addr = addr_q;

   // Stage 0: place fields by format and classify the immediate.
   always_comb begin
      enc_inst = {opcode[11:6], rs, rt, 16'h0000};
      enc_err  = 1'b0;
      if (opcode[11:6] == OP_RTYPE) begin
         enc_inst[15:11] = rd;
         enc_inst[5:0]   = opcode[5:0];
         if (is_shift(opcode[5:0])) begin
            enc_inst[10:6] = imm[4:0];
            enc_err        = ~fits_shamt(imm);
         end
      end else begin
         enc_inst[15:0] = imm[15:0];
         case (opcode[11:6])
            OP_ANDI, OP_ORI, OP_XORI:
               enc_err = ~fits_zext16(imm);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_SLTI:
               enc_err = ~fits_sext16(imm);
            default:
               enc_err = 1'b1;
         endcase
      end
   end

   // Stage 1 occupancy: fills on input transfer, holds while stage 2 stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_p1 <= 1'b0;
      else      vld_p1 <= in_fire | (vld_p1 & ~adv_p2);
   end

   // Stage 1 data: packed word and check result, loaded on input transfer.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         inst_p1 <= enc_inst;
         err_p1  <= enc_err;
      end
   end

   // Stage 2: output register; rejected words are presented as all zeros.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_inst  <= 32'h0000_0000;
         out_err   <= 1'b0;
      end else if (adv_p2) begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            out_inst <= err_p1 ? 32'h0000_0000 : inst_p1;
            out_err  <= err_p1;
         end
      end
   end

   // Address of the word in stage 2; clear beats the increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          addr_q <= BASE_ADDR;
      else if (addr_clr) addr_q <= BASE_ADDR;
      else if (out_fire) addr_q <= addr_q + ADDR_STEP;
   end

`ifdef INST_ENC_ERRCNT_EN
   logic [7:0] err_cnt_q;

   // Count delivered rejected words, sticking at 8'hFF.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_cnt_q <= 8'h00;
      else if (out_fire && out_err && (err_cnt_q != 8'hFF))
         err_cnt_q <= err_cnt_q + 8'h01;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'h00;
`endif

endmodule
